// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller for the pipelined RV32 core.
//
// Sits downstream of the Memory stage. It turns an M-stage load or store into a
// request/acknowledge transaction on the data bus. Stores use byte lanes. A load
// returns the raw aligned word on MemDataM, and StallMemM holds the pipeline
// while the transaction is outstanding.
//
// Optional feature: define DMEM_CTRL_TIMEOUT_EN to abort a request that gets
// no bus_ack within TO_CYCLES REQ cycles. The abort pulses BusErrM and returns
// zero data for loads. Without the macro the controller waits indefinitely.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   MemReadM, MemWriteM    M-stage load / store strobes (both high = store)
//   ALUResultM             byte address
//   WriteDataM             store data (low bits significant)
//   InstrM                 funct3: [1:0] size (b/h/w), [2] unsigned load
//   MemDataM               registered word from the last completed load
//   StallMemM              hold F/D/E/M stages
//   MisalignM              misaligned access present this cycle
//   BusErrM                one-cycle pulse after a timeout abort
//   bus_req/we/addr/wdata/be   registered bus request fields
//   bus_rdata, bus_ack     bus response
module dmem_ctrl #(
    parameter int unsigned TO_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  InstrM,
    output logic [31:0] MemDataM,
    output logic        StallMemM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} stateE;

    stateE       state, stateNext;
    logic        access, misalign, issue, toHit;
    logic [1:0]  size;
    logic [3:0]  beNext;
    logic [31:0] wdataNext;

    // Signedness only matters to the load decoder.
    logic unusedSignBit;
    assign unusedSignBit = InstrM[2];

    assign size = InstrM[1:0];

    // Access decode and alignment check.
    always_comb begin
        access   = MemReadM | MemWriteM;
        misalign = 1'b0;
        case (size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ALUResultM[0];
            default: misalign = |ALUResultM[1:0];
        endcase
        issue = access & ~misalign;
    end

    // Store lane steering. Loads always fetch the full word.
    always_comb begin
        beNext    = 4'b1111;
        wdataNext = WriteDataM;
        case (size)
            2'b00: begin
                beNext    = 4'b0001 << ALUResultM[1:0];
                wdataNext = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                beNext    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdataNext = {2{WriteDataM[15:0]}};
            end
            default: begin
                beNext    = 4'b1111;
                wdataNext = WriteDataM;
            end
        endcase
        if (!MemWriteM) begin
            beNext = 4'b1111;
        end
    end

`ifdef DMEM_CTRL_TIMEOUT_EN
    logic [7:0] toCnt;

    // The counter sits at zero outside REQ, so it starts cleared on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            toCnt <= 8'd0;
        end else if (state != StReq) begin
            toCnt <= 8'd0;
        end else if (!bus_ack) begin
            toCnt <= toCnt + 8'd1;
        end
    end

    // This REQ cycle is the last one allowed.
    assign toHit = (toCnt == 8'(TO_CYCLES - 1));

    // An ack in the limit cycle wins, so no error is raised then.
    always_ff @(posedge clk) begin
        if (reset) begin
            BusErrM <= 1'b0;
        end else begin
            BusErrM <= (state == StReq) && !bus_ack && toHit;
        end
    end
`else
    assign toHit   = 1'b0;
    assign BusErrM = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            StIdle: if (issue) stateNext = StReq;
            StReq:  if (bus_ack || toHit) stateNext = StDone;
            StDone: stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    // Outputs. StallMemM is low in DONE so the held instruction is not reissued.
    always_comb begin
        StallMemM = ((state == StIdle) && issue) || (state == StReq);
        MisalignM = access & misalign;
    end

    // Bus request fields and the load data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'd0;
            MemDataM  <= 32'd0;
        end else begin
            bus_req <= (stateNext == StReq);
            if ((state == StIdle) && issue) begin
                bus_we    <= MemWriteM;
                bus_addr  <= {ALUResultM[31:2], 2'b00};
                bus_be    <= beNext;
                bus_wdata <= wdataNext;
            end
            if (state == StReq) begin
                if (bus_ack) begin
                    if (!bus_we) MemDataM <= bus_rdata;
                end else if (toHit) begin
                    if (!bus_we) MemDataM <= 32'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl. It applies table-driven single transactions,
// then runs hand-written sequences for back-to-back accesses, timeout or
// indefinite wait, and reset in the middle of a transaction.
module tb_dmem_ctrl;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [2:0]  InstrM;
    logic [31:0] MemDataM;
    logic        StallMemM, MisalignM, BusErrM;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int nChecks = 0;
    int nFails  = 0;

    dmem_ctrl #(.TO_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .InstrM     (InstrM),
        .MemDataM   (MemDataM),
        .StallMemM  (StallMemM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges of bus_req to detect duplicate requests.
    logic reqPrev = 1'b0;
    int   reqRises = 0;
    always @(posedge clk) begin
        if (bus_req && !reqPrev) reqRises <= reqRises + 1;
        reqPrev <= bus_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          ackDly;
        logic [31:0] rdata;
        logic        expMis;
        logic [3:0]  expBe;
        logic [31:0] expAddr;
        logic [31:0] expWdata;
        logic [31:0] expMem;
    } vecT;

    vecT vecs[12];

    task automatic idleInputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        InstrM     = 3'b000;
    endtask

    task automatic setAccess(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] f3);
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUResultM = addr;
        WriteDataM = wdata;
        InstrM     = f3;
    endtask

    // Apply one access in IDLE, ack it in REQ cycle ackDly, and check DONE.
    task automatic applyVec(input int idx, input vecT v);
        int stallCnt;
        @(negedge clk);
        setAccess(v.rd, v.wr, v.addr, v.wdata, v.f3);
        #1;
        chk1($sformatf("v%0d misalign", idx), MisalignM, v.expMis);
        chk1($sformatf("v%0d stall_c0", idx), StallMemM, !v.expMis);
        if (v.expMis) begin
            @(negedge clk);
            chk1($sformatf("v%0d mis_noreq", idx), bus_req, 1'b0);
            chk1($sformatf("v%0d mis_nostall", idx), StallMemM, 1'b0);
            chk32($sformatf("v%0d mis_memdata", idx), MemDataM, v.expMem);
            idleInputs();
        end else begin
            stallCnt = StallMemM ? 1 : 0;
            for (int j = 1; j <= v.ackDly; j++) begin
                @(negedge clk);
                bus_ack   = (j == v.ackDly);
                bus_rdata = (j == v.ackDly) ? v.rdata : 32'h5555_5555;
                #1;
                if (StallMemM) stallCnt++;
                chk1($sformatf("v%0d req_c%0d", idx, j), bus_req, 1'b1);
                if (j == 1) begin
                    chk1($sformatf("v%0d we", idx), bus_we, v.wr);
                    chk32($sformatf("v%0d addr", idx), bus_addr, v.expAddr);
                    chk32($sformatf("v%0d be", idx), {28'd0, bus_be}, {28'd0, v.expBe});
                    if (v.wr) chk32($sformatf("v%0d wdata", idx), bus_wdata, v.expWdata);
                end
            end
            @(negedge clk);
            bus_ack = 1'b0;
            idleInputs();
            #1;
            chk1($sformatf("v%0d done_stall", idx), StallMemM, 1'b0);
            chk1($sformatf("v%0d done_req", idx), bus_req, 1'b0);
            chk32($sformatf("v%0d memdata", idx), MemDataM, v.expMem);
            chk32($sformatf("v%0d stall_cycles", idx), 32'(stallCnt), 32'(v.ackDly + 1));
        end
    endtask

    initial begin
        vecT lim;
        int  risesBefore;

        //          rd    wr    addr          wdata          f3     dly rdata
        //          mis   be       addr          wdata          mem
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 3'b010, 3, 32'hCAFE_BABE,
                     1'b0, 4'b1111, 32'h0000_0100, 32'h0000_0000, 32'hCAFE_BABE};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0203, 32'h1234_56A5, 3'b000, 1, 32'h0000_0000,
                     1'b0, 4'b1000, 32'h0000_0200, 32'hA5A5_A5A5, 32'hCAFE_BABE};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0202, 32'hFFFF_1234, 3'b001, 2, 32'h0000_0000,
                     1'b0, 4'b1100, 32'h0000_0200, 32'h1234_1234, 32'hCAFE_BABE};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0102, 32'h0000_0000, 3'b010, 1, 32'h0000_0000,
                     1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_BABE};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0001, 32'h0000_0000, 3'b100, 1, 32'h1122_3344,
                     1'b0, 4'b1111, 32'h0000_0000, 32'h0000_0000, 32'h1122_3344};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0001, 32'h0000_005A, 3'b000, 1, 32'h0000_0000,
                     1'b0, 4'b0010, 32'h0000_0000, 32'h5A5A_5A5A, 32'h1122_3344};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0201, 32'h0000_BEEF, 3'b001, 1, 32'h0000_0000,
                     1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h1122_3344};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_030C, 32'hDEAD_BEEF, 3'b010, 1, 32'h0000_0000,
                     1'b0, 4'b1111, 32'h0000_030C, 32'hDEAD_BEEF, 32'h1122_3344};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0000_0000, 3'b001, 1, 32'h89AB_CDEF,
                     1'b0, 4'b1111, 32'h0000_0004, 32'h0000_0000, 32'h89AB_CDEF};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0000_0000, 3'b101, 1, 32'h0000_0000,
                     1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h89AB_CDEF};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 3'b010, 1, 32'h7777_7777,
                     1'b0, 4'b1111, 32'h0000_0040, 32'h0BAD_F00D, 32'h89AB_CDEF};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0301, 32'h0000_0000, 3'b010, 1, 32'h0000_0000,
                     1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h89AB_CDEF};

        reset     = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        idleInputs();
        repeat (2) @(negedge clk);
        chk1("rst bus_req", bus_req, 1'b0);
        chk1("rst bus_we", bus_we, 1'b0);
        chk32("rst bus_addr", bus_addr, 32'd0);
        chk32("rst bus_wdata", bus_wdata, 32'd0);
        chk32("rst bus_be", {28'd0, bus_be}, 32'd0);
        chk32("rst MemDataM", MemDataM, 32'd0);
        chk1("rst BusErrM", BusErrM, 1'b0);
        chk1("rst StallMemM", StallMemM, 1'b0);
        chk1("rst MisalignM", MisalignM, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) applyVec(i, vecs[i]);

`ifdef DMEM_CTRL_TIMEOUT_EN
        // No ack: abort after 4 REQ cycles.
        @(negedge clk);
        setAccess(1'b1, 1'b0, 32'h0000_0044, 32'd0, 3'b010);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk1($sformatf("to req_c%0d", j), bus_req, 1'b1);
            chk1($sformatf("to noerr_c%0d", j), BusErrM, 1'b0);
        end
        @(negedge clk);
        idleInputs();
        #1;
        chk1("to req_drop", bus_req, 1'b0);
        chk1("to buserr", BusErrM, 1'b1);
        chk32("to memdata", MemDataM, 32'd0);
        chk1("to stall_rel", StallMemM, 1'b0);
        @(negedge clk);
        chk1("to buserr_pulse", BusErrM, 1'b0);
        // Ack in the limit cycle wins.
        lim = '{1'b1, 1'b0, 32'h0000_0048, 32'd0, 3'b010, 4, 32'h600D_F00D,
                1'b0, 4'b1111, 32'h0000_0048, 32'd0, 32'h600D_F00D};
        applyVec(20, lim);
        chk1("to lim_noerr", BusErrM, 1'b0);
`else
        // No timeout: the request waits far beyond any limit.
        lim = '{1'b1, 1'b0, 32'h0000_0048, 32'd0, 3'b010, 20, 32'h600D_F00D,
                1'b0, 4'b1111, 32'h0000_0048, 32'd0, 32'h600D_F00D};
        applyVec(20, lim);
        chk1("noto buserr", BusErrM, 1'b0);
`endif

        // Back-to-back sw 0x10 then lw 0x10, both with immediate ack.
        risesBefore = reqRises;
        @(negedge clk);
        setAccess(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0077, 3'b010);
        @(negedge clk);
        chk1("b2b sw_req", bus_req, 1'b1);
        chk1("b2b sw_we", bus_we, 1'b1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h9999_9999;
        @(negedge clk);
        bus_ack = 1'b0;
        setAccess(1'b1, 1'b0, 32'h0000_0010, 32'd0, 3'b010);
        #1;
        chk1("b2b done_req", bus_req, 1'b0);
        chk1("b2b done_stall", StallMemM, 1'b0);
        chk32("b2b sw_nodata", MemDataM, 32'h600D_F00D);
        @(negedge clk);
        chk1("b2b idle_req", bus_req, 1'b0);
        chk1("b2b idle_stall", StallMemM, 1'b1);
        @(negedge clk);
        chk1("b2b lw_req", bus_req, 1'b1);
        chk1("b2b lw_we", bus_we, 1'b0);
        chk32("b2b lw_addr", bus_addr, 32'h0000_0010);
        bus_ack   = 1'b1;
        bus_rdata = 32'h600D_CAFE;
        @(negedge clk);
        bus_ack = 1'b0;
        idleInputs();
        #1;
        chk32("b2b lw_data", MemDataM, 32'h600D_CAFE);
        repeat (2) @(negedge clk);
        chk1("b2b final_req", bus_req, 1'b0);
        chk32("b2b req_count", 32'(reqRises - risesBefore), 32'd2);

        // Reset in REQ, then a late ack.
        @(negedge clk);
        setAccess(1'b1, 1'b0, 32'h0000_0080, 32'd0, 3'b010);
        @(negedge clk);
        chk1("rreq req", bus_req, 1'b1);
        reset = 1'b1;
        idleInputs();
        @(negedge clk);
        chk1("rreq req_drop", bus_req, 1'b0);
        chk1("rreq idle", StallMemM, 1'b0);
        chk32("rreq memdata_rst", MemDataM, 32'd0);
        reset     = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus_ack = 1'b0;
        chk32("rreq late_ack", MemDataM, 32'd0);
        chk1("rreq late_noreq", bus_req, 1'b0);
        @(negedge clk);
        chk32("rreq late_ack2", MemDataM, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
